dmem_ctrl: RTL and testbench

//  Two-port arbiter and access sequencer for the 4-lane byte-wide data memory (one 8-bit

---
 rtl/dmem_ctrl_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg
//   Shared types and constants for the data-memory controller.
//   - size_e   : funct3-style access size codes (B, H, W, BU, HU)
//   - state_e  : controller sequencing states
//   - NUM_LANES: byte lanes (one 8-bit bank per lane)
//   - size_err : alignment / reserved-code check for a size and byte offset
package dmem_ctrl_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_e;

    // Misaligned halfword/word, or a size code with no defined meaning.
    function automatic logic size_err(input logic [2:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_B, SZ_BU: err = 1'b0;
            SZ_H, SZ_HU: err = off[0];
            SZ_W:        err = (off != 2'b00);
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Purely combinational byte-lane steering for the 4-lane memory.
//   Store side: lane enables and lane data for a right-justified store word.
//   Load side : selects the addressed bytes from the four lanes and extends them.
// Ports
//   st_size  in  3      store access size code
//   st_off   in  2      store byte offset (addr[1:0])
//   st_wdata in  32     store data, right-justified
//   st_be    out 4      lane enables, lane i = byte i
//   st_lanes out 4x8    lane write data (unused lanes carry shifted garbage)
//   ld_size  in  3      load access size code
//   ld_off   in  2      load byte offset
//   ld_lanes in  4x8    raw lane read data
//   ld_data  out 32     extracted and extended load result
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]                  st_size,
    input  logic [1:0]                  st_off,
    input  logic [31:0]                 st_wdata,
    output logic [NUM_LANES-1:0]        st_be,
    output logic [NUM_LANES-1:0][7:0]   st_lanes,
    input  logic [2:0]                  ld_size,
    input  logic [1:0]                  ld_off,
    input  logic [NUM_LANES-1:0][7:0]   ld_lanes,
    output logic [31:0]                 ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_be = '0;
        case (st_size)
            SZ_B, SZ_BU: st_be = 4'b0001 << st_off;
            SZ_H, SZ_HU: st_be = 4'b0011 << st_off;
            SZ_W:        st_be = 4'b1111;
            default:     st_be = '0;
        endcase
        st_lanes = st_wdata << {st_off, 3'b000};
    end

    always_comb begin
        // Bring the addressed byte/halfword down to bit 0 before extension.
        ld_shift = ld_lanes >> {ld_off, 3'b000};
        ld_data  = '0;
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            SZ_W:    ld_data = ld_shift;
            SZ_BU:   ld_data = {24'h0, ld_shift[7:0]};
            SZ_HU:   ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
//   Two-port round-robin arbiter and access sequencer for a 4-lane byte-wide
//   data memory with a registered read address (1-cycle read latency).
//   Port 0 = CPU load/store, port 1 = debug/loader.
// Handshake: a request transfers in the cycle where req_valid[p] and
//   req_ready[p] are both high; a response transfers in the cycle where
//   rsp_valid[p] and rsp_ready[p] are both high. rsp_valid, rsp_rdata and
//   rsp_err stay stable until that transfer. The controller holds a single
//   access at a time, so at most one ready bit and one rsp_valid bit is high.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/ready [2]  per-port request handshake
//   req_we [2]           1 = store, 0 = load
//   req_size [2][3]      funct3 size code
//   req_addr [2][32]     byte address
//   req_wdata [2][32]    right-justified store data
//   rsp_valid/ready [2]  per-port response handshake
//   rsp_rdata [32]       extended load data; 0 for stores and errors
//   rsp_err              misaligned / out-of-range / reserved size
//   mem_addr [32]        address to all banks (combinational on accept)
//   mem_we [4]           per-lane write enable
//   mem_wdata [4][8]     per-lane write data
//   mem_rdata [4][8]     per-lane read data, one cycle after mem_addr
//   dbg_state            current sequencing state
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][2:0]             req_size,
    input  logic [1:0][31:0]            req_addr,
    input  logic [1:0][31:0]            req_wdata,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_err,
    output logic [31:0]                 mem_addr,
    output logic [NUM_LANES-1:0]        mem_we,
    output logic [NUM_LANES-1:0][7:0]   mem_wdata,
    input  logic [NUM_LANES-1:0][7:0]   mem_rdata,
    output state_e                      dbg_state
);

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        port_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        grant;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        range_err;

    logic [NUM_LANES-1:0]      st_be;
    logic [NUM_LANES-1:0][7:0] st_lanes;
    logic [31:0]               ld_data;

    // Arbiter: grants only in IDLE. On a tie the port opposite the last
    // winner goes; a lone requester always wins. Gated by rst_n so nothing
    // is granted (and no address is driven) while reset is asserted.
    always_comb begin
        accept = 1'b0;
        grant  = 1'b0;
        if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
            accept = 1'b1;
            if (req_valid == 2'b11) begin
                grant = ~last_grant_q;
            end else begin
                grant = req_valid[1];
            end
        end
        sel_we    = req_we[grant];
        sel_size  = req_size[grant];
        sel_addr  = req_addr[grant];
        sel_wdata = req_wdata[grant];
        range_err = ((sel_addr >> ADDR_BITS) != 32'h0);
        sel_err   = size_err(sel_size, sel_addr[1:0]) | range_err;
        req_ready = 2'b00;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    dmem_lane_align u_align (
        .st_size  (sel_size),
        .st_off   (sel_addr[1:0]),
        .st_wdata (sel_wdata),
        .st_be    (st_be),
        .st_lanes (st_lanes),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_lanes (mem_rdata),
        .ld_data  (ld_data)
    );

    // Next state and memory-side outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Stores and errors need no read cycle.
                    state_d = (sel_we || sel_err) ? RSP : RD_WAIT;
                end
            end
            RD_WAIT: state_d = RSP;
            RSP: begin
                // No new grant in the exit cycle: IDLE is entered next cycle.
                if (rsp_ready[port_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_we    = (accept && sel_we && !sel_err) ? st_be : '0;
        mem_wdata = st_lanes;
        mem_addr  = accept ? sel_addr : addr_q;

        rsp_valid = 2'b00;
        if (state_q == RSP) begin
            rsp_valid[port_q] = 1'b1;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            size_q       <= 3'b000;
            off_q        <= 2'b00;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                port_q       <= grant;
                size_q       <= sel_size;
                off_q        <= sel_addr[1:0];
                we_q         <= sel_we;
                err_q        <= sel_err;
                addr_q       <= sel_addr;
                last_grant_q <= grant;
                rdata_q      <= '0;
            end
            if (state_q == RD_WAIT) begin
                rdata_q <= we_q ? 32'h0 : ld_data;
            end
            if ((state_q == RSP) && rsp_ready[port_q]) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]        req_valid, req_ready, req_we;
  logic [1:0][2:0]   req_size;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_we;
  logic [3:0][7:0]   mem_wdata;
  logic [3:0][7:0]   mem_rdata;
  state_e            dbg_state;

  dmem_ctrl #(.ADDR_BITS(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory banks: registered read, 1-cycle latency ----------------
  logic [7:0] bank [4][2048];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) bank[i][mem_addr[12:2]] <= mem_wdata[i];
      mem_rdata[i] <= bank[i][mem_addr[12:2]];
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {port, err, rdata}; due_q holds the cycle the response must first appear
  logic [33:0] exp_q[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [33:0] e;
  bit          prev_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compares on every response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got valid=%b expected none", rsp_valid);
        end else begin
          if (!prev_v) check("rsp_latency", cyc, due_q[0]);
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("rsp_port", 32'(rsp_valid), e[33] ? 32'h2 : 32'h1);
            check("rsp_err", 32'(rsp_err), 32'(e[32]));
            check("rsp_rdata", rsp_rdata, e[31:0]);
          end
        end
      end
      prev_v = |rsp_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int p, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] exp_we, input logic [31:0] exp_lanes,
                       input logic exp_err, input logic [31:0] exp_rdata);
    bit got = 1'b0;
    @(negedge clk);
    req_we[p] = we; req_size[p] = size; req_addr[p] = addr; req_wdata[p] = wdata;
    req_valid[p] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (req_ready[p]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: port %0d never got req_ready", p);
      req_valid[p] = 1'b0;
      return;
    end
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", mem_addr, addr);
    for (int i = 0; i < 4; i++)
      if (exp_we[i]) check("mem_wdata", 32'(mem_wdata[i]), 32'(exp_lanes[8*i +: 8]));
    exp_q.push_back({p[0], exp_err, exp_rdata});
    due_q.push_back(cyc + ((we || exp_err) ? 1 : 2));
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit   got;
    int   ex;
    int   kk;
    logic g;

    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 2048; a++) bank[l][a] = 8'h00;
    mem_rdata = '0;
    rst_n = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_size = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 2'b11;

    // reset values (with requests pending, nothing may be granted)
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // store/load alignment and extension
    issue(0, 1'b1, SZ_W,  32'h10, 32'h1234_5678, 4'hF,    32'h1234_5678, 1'b0, 32'h0);
    issue(0, 1'b0, SZ_W,  32'h10, 32'h0,         4'h0,    32'h0,         1'b0, 32'h1234_5678);
    issue(0, 1'b1, SZ_B,  32'h13, 32'h0000_00AB, 4'b1000, 32'hAB00_0000, 1'b0, 32'h0);
    issue(0, 1'b0, SZ_B,  32'h13, 32'h0,         4'h0,    32'h0,         1'b0, 32'hFFFF_FFAB);
    issue(0, 1'b0, SZ_BU, 32'h13, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0000_00AB);
    issue(0, 1'b1, SZ_H,  32'h12, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0);
    issue(0, 1'b0, SZ_H,  32'h12, 32'h0,         4'h0,    32'h0,         1'b0, 32'hFFFF_BEEF);
    issue(0, 1'b0, SZ_HU, 32'h12, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0000_BEEF);
    issue(0, 1'b0, SZ_H,  32'h10, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0000_5678);

    // errors: misaligned, out of range, misaligned store, reserved size
    issue(0, 1'b0, SZ_H,   32'h11,   32'h0,         4'h0, 32'h0, 1'b1, 32'h0);
    issue(0, 1'b0, SZ_W,   32'h2000, 32'h0,         4'h0, 32'h0, 1'b1, 32'h0);
    issue(0, 1'b1, SZ_W,   32'h12,   32'hDEAD_BEEF, 4'h0, 32'h0, 1'b1, 32'h0);
    issue(0, 1'b0, 3'b011, 32'h0,    32'h0,         4'h0, 32'h0, 1'b1, 32'h0);

    // lone P1: immediate grant; word shows the errored store wrote nothing
    issue(1, 1'b0, SZ_W, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 32'hBEEF_5678);

    // both ports valid: expected grants P0,P1,P0,P1
    for (int k = 0; k < 4; k++) begin
      ex = k % 2;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        kk = (p == ex) ? k : k + 1;
        req_we[p] = 1'b1; req_size[p] = SZ_W;
        req_addr[p] = 32'h100 + 32'(4 * kk);
        req_wdata[p] = 32'hC0DE_0000 + 32'(kk);
      end
      req_valid = 2'b11;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
        #1;
        if (req_ready != 2'b00) begin got = 1'b1; break; end
        @(negedge clk);
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL arb_timeout: got no grant in round %0d", k);
        break;
      end
      check("arb_grant", 32'(req_ready), 32'(1 << ex));
      g = req_ready[1];
      check("arb_mem_we", 32'(mem_we), 32'hF);
      check("arb_mem_addr", mem_addr, req_addr[g]);
      exp_q.push_back({g, 1'b0, 32'h0});
      due_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;

    // response backpressure: held stable, no new grant while stalled
    wait_drain();
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, SZ_W, 32'h100, 32'h0, 4'h0, 32'h0, 1'b0, 32'hC0DE_0000);
    req_we[1] = 1'b0; req_size[1] = SZ_W; req_addr[1] = 32'h104; req_valid[1] = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      check("hold_rsp_rdata", rsp_rdata, 32'hC0DE_0000);
      check("hold_req_ready", 32'(req_ready), 32'h0);
    end
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    wait_drain();

    // reset during RD_WAIT drops the response
    issue(0, 1'b0, SZ_W, 32'h108, 32'h0, 4'h0, 32'h0, 1'b0, 32'hC0DE_0002);
    req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
    check("mid_rst_mem_we", 32'(mem_we), 32'h0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    due_q.delete();
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    issue(0, 1'b0, SZ_W, 32'h104, 32'h0, 4'h0, 32'h0, 1'b0, 32'hC0DE_0001);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
